// File: rtl/seg_time_reader.sv
// seg_time_reader: decodes the two-digit active-low 7-segment countdown bus into a debounced 0..99 time value.
// Optional MONOTONIC_CHECK_EN adds the sticky err_up output for count-up detection.
module seg_time_reader #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] SEG,
  input  logic [6:0] iSEG,
  output logic [7:0] time_bcd,
  output logic [6:0] time_bin,
  output logic       valid,
  output logic       changed,
  output logic       expired,
  output logic       err
`ifdef MONOTONIC_CHECK_EN
  ,
  output logic       err_up
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, TRACK, EXPIRED} state_t;
  state_t state, state_nx;
  logic [13:0] in_q;
  logic [CW-1:0] stab_cnt;
  logic acc, match, pair_ok;
  logic [4:0] dec_t, dec_o;
  logic [7:0] new_bcd;
  logic [6:0] new_bin;
  // Returns {ok, digit}; anything outside the table (X/Z included) decodes as not ok.
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'b1000000: dec = 5'h10;
      7'b1111001: dec = 5'h11;
      7'b0100100: dec = 5'h12;
      7'b0110000: dec = 5'h13;
      7'b0011001: dec = 5'h14;
      7'b0010010: dec = 5'h15;
      7'b0000010: dec = 5'h16;
      7'b1111000: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0011000: dec = 5'h19;
      default:    dec = 5'h00;
    endcase
  endfunction
  assign match   = ({iSEG, SEG} == in_q);
  assign dec_t   = dec(in_q[13:7]);
  assign dec_o   = dec(in_q[6:0]);
  assign pair_ok = dec_t[4] & dec_o[4];
  assign new_bcd = {dec_t[3:0], dec_o[3:0]};
  assign new_bin = {3'b000, dec_t[3:0]} * 7'd10 + {3'b000, dec_o[3:0]};
  assign valid   = (state != IDLE);
  assign expired = (state == EXPIRED);
  // acc is a registered strobe; the decode reads in_q, which still holds the stable pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q     <= 14'h3FFF;
      stab_cnt <= '0;
      acc      <= 1'b0;
    end else begin
      in_q     <= {iSEG, SEG};
      stab_cnt <= !match ? '0 : (stab_cnt == FULL) ? stab_cnt : stab_cnt + 1'b1;
      acc      <= match && (stab_cnt == LAST);
    end
  end
  always_comb begin
    state_nx = state;
    if (acc && pair_ok)
      state_nx = (state == IDLE) ? TRACK :
                 (state == TRACK && new_bin == 7'd0 && time_bin != 7'd0) ? EXPIRED :
                 (state == EXPIRED && new_bin != 7'd0) ? TRACK : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      time_bcd <= 8'h00;
      time_bin <= 7'd0;
      changed  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nx;
      changed <= acc && pair_ok && (state == IDLE || new_bcd != time_bcd);
      if (acc && pair_ok) begin
        time_bcd <= new_bcd;
        time_bin <= new_bin;
      end
      if (acc && !pair_ok) err <= 1'b1;
    end
  end
`ifdef MONOTONIC_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_up <= 1'b0;
    else if (acc && pair_ok && state == TRACK && new_bin > time_bin) err_up <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_seg_time_reader.sv
// tb_seg_time_reader: directed checks of seg_time_reader with a short stability window.
module tb_seg_time_reader;
  localparam int S = 8;
  logic clk = 1'b0;
  logic reset;
  logic [6:0] SEG, iSEG;
  logic [7:0] time_bcd;
  logic [6:0] time_bin;
  logic valid, changed, expired, err;
`ifdef MONOTONIC_CHECK_EN
  logic err_up;
`endif
  int checks = 0;
  int failures = 0;
  int chg_n = 0;
  int chg0;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  seg_time_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .SEG(SEG), .iSEG(iSEG),
    .time_bcd(time_bcd), .time_bin(time_bin), .valid(valid),
    .changed(changed), .expired(expired), .err(err)
`ifdef MONOTONIC_CHECK_EN
    , .err_up(err_up)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (changed === 1'b1) chg_n <= chg_n + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put(input int t, input int o);
    iSEG = pat[t];
    SEG  = pat[o];
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    put(2, 0);
    tick(3);
    chk("reset_bcd", {24'h0, time_bcd}, 32'h00);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    // 1: first acceptance of 20 after S+2 cycles
    reset = 1'b0;
    tick(S + 1);
    chk("t1_not_yet", {31'h0, valid}, 32'h0);
    tick(1);
    chk("t1_bcd", {24'h0, time_bcd}, 32'h20);
    chk("t1_bin", {25'h0, time_bin}, 32'd20);
    chk("t1_valid", {31'h0, valid}, 32'h1);
    chk("t1_changed", {31'h0, changed}, 32'h1);
    tick(1);
    chk("t1_changed_drop", {31'h0, changed}, 32'h0);
    chk("t1_expired", {31'h0, expired}, 32'h0);
    // 2: short glitch on ones digit is rejected
    tick(2 * S);
    chg0 = chg_n;
    put(2, 1);
    tick(S - 1);
    put(2, 0);
    tick(3 * S);
    chk("t2_bcd", {24'h0, time_bcd}, 32'h20);
    chk("t2_nochg", chg_n - chg0, 0);
    chk("t2_err", {31'h0, err}, 32'h0);
    // 3: countdown steps
    chg0 = chg_n; put(1, 9); tick(2 * S);
    chk("t3_19_bin", {25'h0, time_bin}, 32'd19);
    chk("t3_19_chg", chg_n - chg0, 1);
    chg0 = chg_n; put(1, 0); tick(2 * S);
    chk("t3_10_bcd", {24'h0, time_bcd}, 32'h10);
    chk("t3_10_chg", chg_n - chg0, 1);
    chg0 = chg_n; put(0, 1); tick(2 * S);
    chk("t3_01_bin", {25'h0, time_bin}, 32'd1);
    chk("t3_01_chg", chg_n - chg0, 1);
    chk("t3_01_expired", {31'h0, expired}, 32'h0);
    chg0 = chg_n; put(0, 0); tick(2 * S);
    chk("t3_00_bin", {25'h0, time_bin}, 32'd0);
    chk("t3_00_chg", chg_n - chg0, 1);
    chk("t3_00_expired", {31'h0, expired}, 32'h1);
    // 4: blank pair sets err; time holds
    iSEG = 7'h7F; SEG = 7'h7F;
    tick(S + 2);
    chk("t4_err", {31'h0, err}, 32'h1);
    chk("t4_bcd", {24'h0, time_bcd}, 32'h00);
    chg0 = chg_n; put(0, 0); tick(2 * S);
    chk("t4_err_sticky", {31'h0, err}, 32'h1);
    chk("t4_nochg", chg_n - chg0, 0);
    chk("t4_expired", {31'h0, expired}, 32'h1);
    // 5: restart from EXPIRED, then reset mid-count
    chg0 = chg_n; put(2, 0); tick(2 * S);
    chk("t5_expired", {31'h0, expired}, 32'h0);
    chk("t5_chg", chg_n - chg0, 1);
    chk("t5_bin", {25'h0, time_bin}, 32'd20);
    put(1, 5);
    tick(S / 2);
    reset = 1'b1;
    tick(1);
    chk("t5_rst_bcd", {24'h0, time_bcd}, 32'h00);
    chk("t5_rst_bin", {25'h0, time_bin}, 32'd0);
    chk("t5_rst_valid", {31'h0, valid}, 32'h0);
    chk("t5_rst_err", {31'h0, err}, 32'h0);
    chk("t5_rst_expired", {31'h0, expired}, 32'h0);
`ifdef MONOTONIC_CHECK_EN
    chk("t5_rst_err_up", {31'h0, err_up}, 32'h0);
`endif
    reset = 1'b0;
    tick(S + 2);
    chk("t5_15_bcd", {24'h0, time_bcd}, 32'h15);
    chk("t5_15_changed", {31'h0, changed}, 32'h1);
    // 6: expiry, restart, then decreasing and increasing steps
    put(0, 0); tick(2 * S);
    chk("t6_expired", {31'h0, expired}, 32'h1);
    put(2, 0); tick(2 * S);
    chk("t6_restart", {31'h0, expired}, 32'h0);
`ifdef MONOTONIC_CHECK_EN
    chk("t6_restart_err_up", {31'h0, err_up}, 32'h0);
`endif
    put(1, 7); tick(2 * S);
    chk("t6_17_bin", {25'h0, time_bin}, 32'd17);
`ifdef MONOTONIC_CHECK_EN
    chk("t6_down_err_up", {31'h0, err_up}, 32'h0);
`endif
    put(1, 8); tick(2 * S);
    chk("t6_18_bin", {25'h0, time_bin}, 32'd18);
`ifdef MONOTONIC_CHECK_EN
    chk("t6_up_err_up", {31'h0, err_up}, 32'h1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
